// File: rtl/bcd_disp4_pkg.sv
// bcd_disp4_pkg: segment patterns, display constants and BCD clamp shared by bcd_disp4.
package bcd_disp4_pkg;
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction
endpackage

// File: rtl/bcd_disp4_seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low seven-segment pattern ([6:0] = A..G).
module seg7_dec
    import bcd_disp4_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/bcd_disp4.sv
// bcd_disp4: 4-digit multiplexed 7-segment driver with tear-free shadow register.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
module bcd_disp4
    import bcd_disp4_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        ld,
    input  logic [15:0] d,
    input  logic        blank,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q;
    logic [15:0]   staging_q, shadow_q, shadow_d, clamped;
    logic          pend_q, pend_d;
    logic [3:0]    an_raw_q, an_q, an_d, an_sel;
    logic [6:0]    seg_q, dec_seg;
    logic          dp_q, frame_q, tick, dark;
    logic [3:0]    dig;

    assign tick    = cnt_q == CW'(REFRESH_DIV - 1);
    assign clamped = {clamp_bcd(d[15:12]), clamp_bcd(d[11:8]), clamp_bcd(d[7:4]), clamp_bcd(d[3:0])};
    assign dig     = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lz;
    always_comb begin
        lz[3] = shadow_q[15:12] == 4'd0;
        lz[2] = lz[3] && shadow_q[11:8] == 4'd0;
        lz[1] = lz[2] && shadow_q[7:4] == 4'd0;
        lz[0] = 1'b0;
    end
    assign dark = lz[idx_q];
`else
    assign dark = 1'b0;
`endif

    seg7_dec u_dec (.bcd_i(dig), .seg_o(dec_seg));

    // A load on the frame cycle bypasses staging so it lands in the frame starting now.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        an_sel   = dark ? AN_OFF : ~(4'b0001 << idx_q);
        an_d     = blank ? AN_OFF : (tick ? an_sel : an_raw_q);
        shadow_d = frame_q ? (ld ? clamped : (pend_q ? staging_q : shadow_q)) : shadow_q;
        pend_d   = frame_q ? 1'b0 : (ld ? 1'b1 : pend_q);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            staging_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            pend_q    <= 1'b0;
            an_raw_q  <= AN_OFF;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            frame_q  <= tick && idx_q == 2'd3;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            if (ld)
                staging_q <= clamped;
            if (tick) begin
                idx_q    <= idx_q + 2'd1;
                an_raw_q <= an_sel;
                seg_q    <= dark ? SEG_OFF : dec_seg;
                dp_q     <= dark | ~dp_mask[idx_q];
            end
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;
endmodule

// File: tb/tb_bcd_disp4.sv
// tb_bcd_disp4: directed scoreboard bench for bcd_disp4 at REFRESH_DIV=4.
module tb_bcd_disp4;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] d = 16'h0000;
    logic        blank = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    typedef struct {
        int         dig;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    logic [6:0] pat [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    bcd_disp4 #(.REFRESH_DIV(4)) dut (
        .clk(clk), .clr_n(clr_n), .ld(ld), .d(d), .blank(blank), .dp_mask(dp_mask),
        .seg(seg), .dp(dp), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Expected slots of one full frame (digit 0 first) for displayed value v.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            logic [3:0] dg;
            logic off;
            dg  = v[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            off = i > 0 && (v >> (4 * i)) == 16'h0000;
`else
            off = 1'b0;
`endif
            e.dig = i;
            e.an  = off ? 4'hF : ~(4'b0001 << i);
            e.seg = off ? 7'h7F : pat[dg];
            e.dp  = off ? 1'b1 : ~dpm[i];
            sb.push_back(e);
        end
    endtask

    task automatic slot(input int n);
        exp_t e;
        repeat (n) @(negedge clk);
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            chk($sformatf("an d%0d", e.dig), {12'h0, an}, {12'h0, e.an});
            chk($sformatf("seg d%0d", e.dig), {9'h0, seg}, {9'h0, e.seg});
            chk($sformatf("dp d%0d", e.dig), {15'h0, dp}, {15'h0, e.dp});
        end
    endtask

    task automatic load(input logic [15:0] v);
        ld = 1'b1;
        d  = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst seg", {9'h0, seg}, 16'h007F);
        chk("rst dp", {15'h0, dp}, 16'h0001);
        chk("rst an", {12'h0, an}, 16'h000F);
        chk("rst frame", {15'h0, frame}, 16'h0000);
        clr_n = 1'b1;
        // idle frames showing zero
        push_frame(16'h0000, 4'b0000);
        repeat (3) @(negedge clk);
        chk("pre-tick an", {12'h0, an}, 16'h000F);
        slot(1);
        chk("frame low", {15'h0, frame}, 16'h0000);
        slot(4); slot(4); slot(4);
        chk("frame 1", {15'h0, frame}, 16'h0001);
        @(negedge clk);
        chk("frame pulse width", {15'h0, frame}, 16'h0000);
        // mid-frame load stays hidden until the boundary
        push_frame(16'h0000, 4'b0000);
        slot(3); slot(4);
        load(16'h1234);
        push_frame(16'h1234, 4'b0000);
        slot(3); slot(4);
        chk("frame 2", {15'h0, frame}, 16'h0001);
        slot(4); slot(4); slot(4); slot(4);
        chk("frame 3", {15'h0, frame}, 16'h0001);
        // clamp and last-load-wins
        @(negedge clk);
        load(16'h5678);
        load(16'h9ABF);
        push_frame(16'h1234, 4'b0000);
        push_frame(16'h9999, 4'b0000);
        slot(1); slot(4); slot(4); slot(4);
        chk("frame 4", {15'h0, frame}, 16'h0001);
        slot(4); slot(4); slot(4); slot(4);
        chk("frame 5", {15'h0, frame}, 16'h0001);
        // load on the frame cycle
        load(16'h0042);
        push_frame(16'h0042, 4'b0000);
        slot(3); slot(4); slot(4); slot(4);
        chk("frame 6", {15'h0, frame}, 16'h0001);
        // blank with loading continuing underneath
        dp_mask = 4'b0100;
        blank = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk($sformatf("blank an c%0d", i), {12'h0, an}, 16'h000F);
            if (i == 16)
                chk("blank frame", {15'h0, frame}, 16'h0001);
            ld = (i == 2);
            d  = 16'h1234;
        end
        blank = 1'b0;
        push_frame(16'h1234, 4'b0100);
        slot(1); slot(3); slot(4); slot(4);
        chk("frame 8", {15'h0, frame}, 16'h0001);
        // async reset with a pending load
        dp_mask = 4'b0000;
        @(negedge clk);
        load(16'h5555);
        repeat (11) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("async seg", {9'h0, seg}, 16'h007F);
        chk("async dp", {15'h0, dp}, 16'h0001);
        chk("async an", {12'h0, an}, 16'h000F);
        chk("async frame", {15'h0, frame}, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        push_frame(16'h0000, 4'b0000);
        repeat (3) @(negedge clk);
        chk("post-rst an", {12'h0, an}, 16'h000F);
        slot(1); slot(4); slot(4); slot(4);
        chk("post-rst frame", {15'h0, frame}, 16'h0001);
        chk("scoreboard drained", 16'(sb.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
